cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, datapath word width.
REQ-002 The block SHALL have parameter LOG_2_BIT_WIDTH, default 4, width of the datapath iteration index.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, number of requesters (1..16).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: reset  input  1  asynchronous active-high reset.
REQ-007 Port: req_valid  input  NUM_REQ  per-requester request.
REQ-008 Port: req_target  input  NUM_REQ*BIT_WIDTH  per-requester target angle; slice k is [k*BIT_WIDTH +: BIT_WIDTH].
REQ-009 Port: req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-010 Port: dp_load_regs, dp_add, dp_sub, dp_iter  output  1 each  datapath controls.
REQ-011 Port: dp_target  output  BIT_WIDTH  target driven to the datapath.
REQ-012 Port: dp_reached_target, dp_dir  input  1 each  datapath status.
REQ-013 Port: dp_x, dp_y  input  BIT_WIDTH each  datapath magnitudes.
REQ-014 Port: res_valid  output  1;  res_ready  input  1;  res_x, res_y  output  BIT_WIDTH;  res_id  output  clog2(NUM_REQ) (min 1).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, ROTATE, DONE.
REQ-016 IDLE: if any req_valid is high, the block SHALL grant one requester round-robin (search starting at last_grant+1, wrapping), pulse req_ready[grant] for that cycle only, latch the target and id, and go to LOAD; otherwise stay in IDLE.
REQ-017 LOAD: the block SHALL assert dp_load_regs for exactly one cycle with dp_target = latched target, then go to ROTATE.
REQ-018 ROTATE: each cycle the block SHALL assert dp_add = dp_dir, dp_sub = !dp_dir (never both), and dp_iter = !dp_reached_target.
REQ-019 ROTATE: when dp_reached_target is high, the block SHALL perform that final step and go to DONE; this gives exactly BIT_WIDTH rotation cycles.
REQ-020 DONE: the block SHALL hold res_valid high, drive res_x = dp_x and res_y = dp_y, and assert no datapath control; on res_valid && res_ready it SHALL go to IDLE.
REQ-021 Latency: for acceptance in cycle T, res_valid SHALL first be high in cycle T+2+BIT_WIDTH.
REQ-022 req_valid and req_target SHALL be sampled only in IDLE; requests that drop before being granted are lost without error.
REQ-023 The block SHALL not accept a new request in the cycle res_ready completes a result; the next grant is no earlier than the following cycle.
REQ-024 last_grant SHALL update only on a grant; with NUM_REQ = 1 every grant goes to requester 0.
REQ-025 Target 0 and target all-ones SHALL still take the full BIT_WIDTH rotation cycles.

Reset
REQ-026 Reset SHALL force state IDLE and last_grant = NUM_REQ-1, so requester 0 wins first.
REQ-027 While in reset, req_ready, all dp_* controls, dp_target, res_valid, and res_id SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation without producing a result.

Configuration
REQ-029 With macro CORDIC_SCHED_PERF_EN defined, the block SHALL add output perf_ops [15:0] (reset 0), incremented on each res_valid && res_ready and wrapping at 16'hFFFF to 0.
REQ-030 Without CORDIC_SCHED_PERF_EN, the perf_ops port and its counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-031 The shared package cordic_pkg SHALL hold the FSM state enum typedef and the default width constants.
REQ-032 Round-robin selection SHALL be one sub-module, cordic_rr_arb (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Setup BIT_WIDTH=16, NUM_REQ=4, single req_valid[2] with target 16'h2000, res_ready=1 -> req_ready[2] pulses once; res_valid rises 18 cycles after the grant; res_id=2.
REQ-034 All four req_valid held high for 4 operations -> grant order 0,1,2,3, then 0 again.
REQ-035 res_ready held low for 10 cycles in DONE -> res_valid, res_x, res_y stable; no dp_* asserted; no req_ready.
REQ-036 Reset asserted at the 5th ROTATE cycle -> all outputs 0 immediately; after release, a new req_valid[1] is granted to requester 1 before any other.
REQ-037 Model dp_dir alternating 1,0,... -> dp_add/dp_sub alternate and are mutually exclusive; dp_iter falls in the cycle dp_reached_target is high; exactly 16 steps.
REQ-038 With CORDIC_SCHED_PERF_EN, run 3 operations -> perf_ops=3; preload 16'hFFFF and complete 1 operation -> perf_ops=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and default widths for the CORDIC request scheduler.
package cordic_pkg;

  localparam int DEF_BIT_WIDTH       = 16;
  localparam int DEF_LOG_2_BIT_WIDTH = 4;
  localparam int DEF_NUM_REQ         = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_DONE   = 2'd3
  } cordic_state_e;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module cordic_rr_arb
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!grant_any && req[(int'(ptr) + off) % NUM_REQ]) begin
        grant[(int'(ptr) + off) % NUM_REQ] = 1'b1;
        grant_idx = ID_W'((int'(ptr) + off) % NUM_REQ);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Schedules requesters onto one shared CORDIC rotation datapath.
// Define CORDIC_SCHED_PERF_EN to add the perf_ops completed-operation counter.
//
// Handshakes: a request is taken when req_ready[k] pulses (only in IDLE, at
// most one bit); a result transfers on the cycle res_valid && res_ready, and
// res_valid/res_x/res_y/res_id stay stable until then.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter  int BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter  int LOG_2_BIT_WIDTH = DEF_LOG_2_BIT_WIDTH,
  parameter  int NUM_REQ         = DEF_NUM_REQ,
  localparam int ID_W            = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_target,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         dp_load_regs,
  output logic                         dp_add,
  output logic                         dp_sub,
  output logic                         dp_iter,
  output logic [BIT_WIDTH-1:0]         dp_target,
  input  logic                         dp_reached_target,
  input  logic                         dp_dir,
  input  logic [BIT_WIDTH-1:0]         dp_x,
  input  logic [BIT_WIDTH-1:0]         dp_y,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [BIT_WIDTH-1:0]         res_x,
  output logic [BIT_WIDTH-1:0]         res_y,
  output logic [ID_W-1:0]              res_id,
`ifdef CORDIC_SCHED_PERF_EN
  output logic [15:0]                  perf_ops,
`endif
  output cordic_state_e                dbg_state,
  output logic [LOG_2_BIT_WIDTH-1:0]   dbg_rot_cnt
);

  cordic_state_e              state_q, state_d;
  logic [ID_W-1:0]            last_grant_q;
  logic [ID_W-1:0]            id_q;
  logic [BIT_WIDTH-1:0]       target_q;
  logic [LOG_2_BIT_WIDTH-1:0] rot_cnt_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               grant_fire;

  cordic_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (last_grant_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign grant_fire  = (state_q == ST_IDLE) && arb_any && !reset;
  assign res_id      = id_q;
  assign dbg_state   = state_q;
  assign dbg_rot_cnt = rot_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      target_q     <= '0;
      rot_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        last_grant_q <= arb_idx;
        id_q         <= arb_idx;
        target_q     <= req_target[arb_idx*BIT_WIDTH +: BIT_WIDTH];
      end
      if (state_q == ST_LOAD) begin
        rot_cnt_q <= '0;
      end else if (state_q == ST_ROTATE) begin
        rot_cnt_q <= rot_cnt_q + LOG_2_BIT_WIDTH'(1);
      end
    end
  end

  // Outputs are forced quiet while reset is held, even though state is IDLE.
  always_comb begin
    state_d      = state_q;
    req_ready    = '0;
    dp_load_regs = 1'b0;
    dp_add       = 1'b0;
    dp_sub       = 1'b0;
    dp_iter      = 1'b0;
    dp_target    = '0;
    res_valid    = 1'b0;
    res_x        = '0;
    res_y        = '0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            req_ready = arb_grant;
            state_d   = ST_LOAD;
          end
        end
        ST_LOAD: begin
          dp_load_regs = 1'b1;
          dp_target    = target_q;
          state_d      = ST_ROTATE;
        end
        ST_ROTATE: begin
          // The step on which the datapath reports reached is still taken.
          dp_add  = dp_dir;
          dp_sub  = !dp_dir;
          dp_iter = !dp_reached_target;
          if (dp_reached_target) state_d = ST_DONE;
        end
        ST_DONE: begin
          res_valid = 1'b1;
          res_x     = dp_x;
          res_y     = dp_y;
          if (res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef CORDIC_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops <= '0;
    end else if (res_valid && res_ready) begin
      perf_ops <= perf_ops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural datapath model plus round-robin reference.
module tb_cordic_sched;
  import cordic_pkg::*;

  localparam int BW  = 16;
  localparam int LBW = 4;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_target;
  logic [NR-1:0]     req_ready;
  logic              dp_load_regs, dp_add, dp_sub, dp_iter;
  logic [BW-1:0]     dp_target;
  logic              dp_reached_target, dp_dir;
  logic [BW-1:0]     dp_x, dp_y;
  logic              res_valid, res_ready;
  logic [BW-1:0]     res_x, res_y;
  logic [IDW-1:0]    res_id;
  cordic_state_e     dbg_state;
  logic [LBW-1:0]    dbg_rot_cnt;
`ifdef CORDIC_SCHED_PERF_EN
  logic [15:0]       perf_ops;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_last;
  logic [IDW-1:0] exp_q[$];
  logic [BW-1:0]  dir_pattern;

  always #5 clk = ~clk;

  cordic_sched #(
    .BIT_WIDTH(BW), .LOG_2_BIT_WIDTH(LBW), .NUM_REQ(NR)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
    .dp_load_regs(dp_load_regs), .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter),
    .dp_target(dp_target), .dp_reached_target(dp_reached_target), .dp_dir(dp_dir),
    .dp_x(dp_x), .dp_y(dp_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_id(res_id),
`ifdef CORDIC_SCHED_PERF_EN
    .perf_ops(perf_ops),
`endif
    .dbg_state(dbg_state), .dbg_rot_cnt(dbg_rot_cnt)
  );

  // Datapath model: after a load it takes BW steps and reports reached on the last.
  logic          dm_active;
  int            dm_n;
  logic [BW-1:0] dm_dirs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_active <= 1'b0;
      dm_n      <= 0;
      dm_dirs   <= '0;
    end else if (dp_load_regs) begin
      dm_active <= 1'b1;
      dm_n      <= 0;
      dm_dirs   <= dir_pattern;
    end else if (dm_active && (dp_add || dp_sub)) begin
      if (dm_n == BW - 1) dm_active <= 1'b0;
      dm_n <= dm_n + 1;
    end
  end

  assign dp_reached_target = dm_active && (dm_n == BW - 1);
  assign dp_dir            = dm_active ? dm_dirs[dm_n % BW] : 1'b0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int off = 1; off <= NR; off++) begin
      if (v[(last + off) % NR]) return (last + off) % NR;
    end
    return -1;
  endfunction

  // Driver: offer requests, wait for a grant, follow the op to its result.
  task automatic run_op(input logic [NR-1:0] v, input logic [NR*BW-1:0] tg, input bit drop,
                        output int gid, output int ones, output int lat,
                        output logic [BW-1:0] ld_tgt, output int rot, output int extra,
                        output logic [IDW-1:0] rid, output logic [BW-1:0] rx,
                        output logic [BW-1:0] ry, output bit tmo);
    gid = -1; ones = 0; lat = -1; rot = 0; extra = 0; tmo = 1'b0;
    ld_tgt = '0; rid = '0; rx = '0; ry = '0;
    @(posedge clk); #1;
    req_valid = v; req_target = tg; res_ready = 1'b1;
    for (int c = 0; c < 40 && gid < 0; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ones = $countones(req_ready);
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) gid = i;
      end
    end
    if (gid < 0) begin
      tmo = 1'b1;
      return;
    end
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      if (c == 1 && drop) req_valid = '0;
      @(negedge clk);
      if (req_ready != '0) extra++;
      if (dp_load_regs) ld_tgt = dp_target;
      if (dp_add || dp_sub) rot++;
      if (res_valid) begin
        lat = c; rid = res_id; rx = res_x; ry = res_y;
        return;
      end
    end
    tmo = 1'b1;
  endtask

  task automatic wait_res(output bit tmo);
    tmo = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (res_valid) begin
        tmo = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_target = {$urandom, $urandom};
    res_ready = 1'b1; dp_x = '0; dp_y = '0; dir_pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    tests_run++;
    if ({dp_load_regs, dp_add, dp_sub, dp_iter} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_dp_ctrl: got %b expected 0000", {dp_load_regs, dp_add, dp_sub, dp_iter});
    end
    tests_run++;
    if (dp_target !== '0) begin tests_failed++; $display("FAIL reset_dp_target: got %h expected 0", dp_target); end
    tests_run++;
    if (res_valid !== 1'b0 || res_id !== '0) begin
      tests_failed++; $display("FAIL reset_res: got valid=%b id=%0d expected 0/0", res_valid, res_id);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0;
    exp_last = NR - 1;
  endtask

  task automatic test_single();
    int gid, ones, lat, rot, extra, exp_g;
    logic [BW-1:0] ld_tgt, rx, ry;
    logic [IDW-1:0] rid;
    logic [NR*BW-1:0] tg;
    bit tmo;
    dp_x = BW'($urandom); dp_y = BW'($urandom); dir_pattern = BW'($urandom);
    tg = {$urandom, $urandom};
    tg[2*BW +: BW] = 16'h2000;
    exp_g = rr_pick(4'b0100, exp_last);
    exp_q.push_back(IDW'(exp_g));
    run_op(4'b0100, tg, 1'b1, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
    tests_run++;
    if (tmo) begin tests_failed++; $display("FAIL single_timeout: got timeout expected result"); end
    tests_run++;
    if (gid != exp_g || ones != 1) begin
      tests_failed++; $display("FAIL single_grant: got id=%0d bits=%0d expected id=%0d bits=1", gid, ones, exp_g);
    end
    tests_run++;
    if (ld_tgt !== 16'h2000) begin tests_failed++; $display("FAIL single_load_target: got %h expected 2000", ld_tgt); end
    tests_run++;
    if (lat != BW + 2) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", lat, BW + 2); end
    tests_run++;
    if (rot != BW) begin tests_failed++; $display("FAIL single_rot_cycles: got %0d expected %0d", rot, BW); end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("FAIL single_extra_ready: got %0d expected 0", extra); end
    tests_run++;
    if (rid !== exp_q.pop_front()) begin tests_failed++; $display("FAIL single_res_id: got %0d expected %0d", rid, exp_g); end
    tests_run++;
    if (rx !== dp_x || ry !== dp_y) begin
      tests_failed++; $display("FAIL single_res_xy: got %h/%h expected %h/%h", rx, ry, dp_x, dp_y);
    end
    exp_last = exp_g;
  endtask

  task automatic test_round_robin();
    int gid, ones, lat, rot, extra, exp_g;
    logic [BW-1:0] ld_tgt, rx, ry;
    logic [IDW-1:0] rid;
    bit tmo;
    for (int n = 0; n < 5; n++) begin
      dir_pattern = BW'($urandom);
      exp_g = rr_pick(4'b1111, exp_last);
      run_op(4'b1111, {$urandom, $urandom}, 1'b0, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
      tests_run++;
      if (tmo || gid != exp_g || rid !== IDW'(exp_g)) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got grant=%0d id=%0d tmo=%0b expected %0d", n, gid, rid, tmo, exp_g);
      end
      tests_run++;
      if (lat != BW + 2) begin tests_failed++; $display("FAIL rr_latency[%0d]: got %0d expected %0d", n, lat, BW + 2); end
      exp_last = exp_g;
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int exp_g;
    bit tmo, got;
    logic [BW-1:0] cx, cy;
    logic [NR-1:0] e1;
    dp_x = BW'($urandom); dp_y = BW'($urandom); dir_pattern = BW'($urandom);
    @(posedge clk); #1;
    req_valid = 4'b0001; req_target = {$urandom, $urandom}; res_ready = 1'b0;
    exp_g = rr_pick(4'b0001, exp_last);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    tests_run++;
    if (!got || req_ready[exp_g] !== 1'b1) begin tests_failed++; $display("FAIL bp_grant: got %b expected bit %0d", req_ready, exp_g); end
    exp_last = exp_g;
    @(posedge clk); #1;
    req_valid = 4'b1110;
    wait_res(tmo);
    tests_run++;
    if (tmo) begin tests_failed++; $display("FAIL bp_timeout: got timeout expected res_valid"); end
    cx = res_x; cy = res_y;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (res_valid !== 1'b1 || res_x !== cx || res_y !== cy || cx !== dp_x || cy !== dp_y) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got v=%b x=%h y=%h expected 1 %h %h", c, res_valid, res_x, res_y, dp_x, dp_y);
      end
      tests_run++;
      if ({dp_load_regs, dp_add, dp_sub, dp_iter} !== 4'b0 || req_ready !== '0) begin
        tests_failed++; $display("FAIL bp_quiet[%0d]: got dp=%b ready=%b expected 0", c,
                                 {dp_load_regs, dp_add, dp_sub, dp_iter}, req_ready);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== '0) begin tests_failed++; $display("FAIL bp_no_grant_on_complete: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    exp_g = rr_pick(4'b1110, exp_last);
    e1 = '0; e1[exp_g] = 1'b1;
    tests_run++;
    if (req_ready !== e1) begin tests_failed++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, e1); end
    exp_last = exp_g;
    @(posedge clk); #1;
    req_valid = '0;
    wait_res(tmo);
    tests_run++;
    if (tmo || res_id !== IDW'(exp_g)) begin tests_failed++; $display("FAIL bp_next_id: got %0d expected %0d", res_id, exp_g); end
  endtask

  task automatic test_reset_mid();
    int exp_g, rn, gid, ones, lat, rot, extra;
    bit got, tmo;
    logic [BW-1:0] ld_tgt, rx, ry;
    logic [IDW-1:0] rid;
    dir_pattern = BW'($urandom);
    @(posedge clk); #1;
    req_valid = 4'b0100; req_target = {$urandom, $urandom}; res_ready = 1'b1;
    exp_g = rr_pick(4'b0100, exp_last);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    tests_run++;
    if (!got || req_ready[exp_g] !== 1'b1) begin tests_failed++; $display("FAIL mid_grant: got %b expected bit %0d", req_ready, exp_g); end
    @(posedge clk); #1;
    req_valid = '0;
    rn = 0;
    for (int c = 0; c < 40 && rn < 5; c++) begin
      @(negedge clk);
      if (dp_add || dp_sub) rn++;
    end
    tests_run++;
    if (rn != 5) begin tests_failed++; $display("FAIL mid_rotate_reach: got %0d steps expected 5", rn); end
    #1;
    req_valid = '1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== '0 || {dp_load_regs, dp_add, dp_sub, dp_iter} !== 4'b0 || dp_target !== '0) begin
      tests_failed++; $display("FAIL mid_reset_ctrl: got ready=%b dp=%b tgt=%h expected 0", req_ready,
                               {dp_load_regs, dp_add, dp_sub, dp_iter}, dp_target);
    end
    tests_run++;
    if (res_valid !== 1'b0 || res_id !== '0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL mid_reset_res: got v=%b id=%0d st=%0d expected 0/0/0", res_valid, res_id, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    exp_last = NR - 1;
    exp_g = rr_pick(4'b1110, exp_last);
    run_op(4'b1110, {$urandom, $urandom}, 1'b1, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
    tests_run++;
    if (tmo || gid != exp_g || rid !== IDW'(exp_g)) begin
      tests_failed++; $display("FAIL mid_after_reset_grant: got %0d id=%0d expected %0d", gid, rid, exp_g);
    end
    exp_last = exp_g;
  endtask

  task automatic test_dir_alternate();
    int exp_g, steps;
    bit got, done;
    dir_pattern = 16'h5555;
    @(posedge clk); #1;
    req_valid = 4'b0001; req_target = {$urandom, $urandom}; res_ready = 1'b1;
    exp_g = rr_pick(4'b0001, exp_last);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    tests_run++;
    if (!got || req_ready[exp_g] !== 1'b1) begin tests_failed++; $display("FAIL alt_grant: got %b expected bit %0d", req_ready, exp_g); end
    exp_last = exp_g;
    @(posedge clk); #1;
    req_valid = '0;
    steps = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (dp_add || dp_sub) begin
        tests_run++;
        if ((dp_add && dp_sub) || dp_add !== (steps % 2 == 0)) begin
          tests_failed++; $display("FAIL alt_dir[%0d]: got add=%b sub=%b expected add=%0d", steps, dp_add, dp_sub, steps % 2 == 0);
        end
        tests_run++;
        if (dp_iter !== (steps != BW - 1)) begin
          tests_failed++; $display("FAIL alt_iter[%0d]: got %b expected %0d", steps, dp_iter, steps != BW - 1);
        end
        steps++;
      end
      if (res_valid) done = 1'b1;
    end
    tests_run++;
    if (!done || steps != BW) begin tests_failed++; $display("FAIL alt_step_count: got %0d done=%0b expected %0d", steps, done, BW); end
  endtask

  task automatic test_random();
    int gid, ones, lat, rot, extra, exp_g;
    logic [BW-1:0] ld_tgt, rx, ry;
    logic [IDW-1:0] rid;
    logic [NR*BW-1:0] tg;
    logic [NR-1:0] v;
    bit tmo;
    for (int n = 0; n < 12; n++) begin
      v = NR'($urandom_range(1, (1 << NR) - 1));
      tg = {$urandom, $urandom};
      if (n == 0) tg = '0;
      if (n == 1) tg = '1;
      dp_x = BW'($urandom); dp_y = BW'($urandom); dir_pattern = BW'($urandom);
      exp_g = rr_pick(v, exp_last);
      exp_q.push_back(IDW'(exp_g));
      run_op(v, tg, 1'b1, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
      tests_run++;
      if (tmo || gid != exp_g || ones != 1) begin
        tests_failed++; $display("FAIL rand_grant[%0d]: got %0d bits=%0d tmo=%0b expected %0d", n, gid, ones, tmo, exp_g);
      end
      tests_run++;
      if (ld_tgt !== tg[exp_g*BW +: BW]) begin
        tests_failed++; $display("FAIL rand_target[%0d]: got %h expected %h", n, ld_tgt, tg[exp_g*BW +: BW]);
      end
      tests_run++;
      if (lat != BW + 2 || rot != BW) begin
        tests_failed++; $display("FAIL rand_timing[%0d]: got lat=%0d rot=%0d expected %0d/%0d", n, lat, rot, BW + 2, BW);
      end
      tests_run++;
      if (rid !== exp_q.pop_front() || rx !== dp_x || ry !== dp_y) begin
        tests_failed++; $display("FAIL rand_result[%0d]: got id=%0d x=%h y=%h expected %0d %h %h", n, rid, rx, ry, exp_g, dp_x, dp_y);
      end
      exp_last = exp_g;
    end
  endtask

`ifdef CORDIC_SCHED_PERF_EN
  task automatic test_perf();
    int gid, ones, lat, rot, extra;
    logic [BW-1:0] ld_tgt, rx, ry;
    logic [IDW-1:0] rid;
    bit tmo;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_last = NR - 1;
    for (int n = 0; n < 3; n++) begin
      run_op(4'b0001, {$urandom, $urandom}, 1'b1, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (perf_ops !== 16'd3) begin tests_failed++; $display("FAIL perf_count: got %0d expected 3", perf_ops); end
    run_op(4'b0001, {$urandom, $urandom}, 1'b1, gid, ones, lat, ld_tgt, rot, extra, rid, rx, ry, tmo);
    force dut.perf_ops = 16'hFFFF;
    #1;
    release dut.perf_ops;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (perf_ops !== 16'd0) begin tests_failed++; $display("FAIL perf_wrap: got %h expected 0000", perf_ops); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_dir_alternate();
    test_random();
`ifdef CORDIC_SCHED_PERF_EN
    test_perf();
`endif
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
